seq_magnitude_comparator: RTL

Parametrised, multi-cycle magnitude comparator with cascade inputs. It is the wide successor of the 8-bit cascadable comparator. Operands are compared one SLICE-bit slice per clock, MSB slice first, and the comparison terminates early on the first unequal slice. The lt/eq/gt cascade inputs break ties when all slices are equal, so instances can be chained for operands wider than WIDTH. Results are held in registers and signalled through a start/busy/done handshake.

---
 rtl/seq_magnitude_comparator.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle sliced magnitude comparator with cascade inputs
// Optional signed MSB-slice compare is built when SIGNED_CMP_EN is defined.
module seq_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             l,
  input  logic             e,
  input  logic             g,
`ifdef SIGNED_CMP_EN
  input  logic             signed_i,
`endif
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             l_q, l_d, e_q, e_d, g_q, g_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic [SLICE-1:0] a_sl, b_sl;
  logic             slice_lt, slice_gt;
`ifdef SIGNED_CMP_EN
  logic             sgn_q, sgn_d;
`endif

  always_comb begin
    a_sl = a_q[int'(idx_q)*SLICE +: SLICE];
    b_sl = b_q[int'(idx_q)*SLICE +: SLICE];
`ifdef SIGNED_CMP_EN
    // Flipping the sign bits turns a two's-complement compare into an unsigned one.
    if (sgn_q && (idx_q == IDX_TOP)) begin
      a_sl[SLICE-1] = ~a_sl[SLICE-1];
      b_sl[SLICE-1] = ~b_sl[SLICE-1];
    end
`endif
    slice_lt = (a_sl < b_sl);
    slice_gt = (a_sl > b_sl);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    l_d     = l_q;
    e_d     = e_q;
    g_d     = g_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
`ifdef SIGNED_CMP_EN
    sgn_d   = sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          l_d     = l;
          e_d     = e;
          g_d     = g;
`ifdef SIGNED_CMP_EN
          sgn_d   = signed_i;
`endif
          idx_d   = IDX_TOP;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (slice_lt || slice_gt) begin
          lt_d    = slice_lt;
          eq_d    = 1'b0;
          gt_d    = slice_gt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          // Cascade priority e > l > g; an all-zero cascade resolves to equal.
          eq_d    = e_q || (!l_q && !g_q);
          lt_d    = !e_q && l_q;
          gt_d    = !e_q && !l_q && g_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
`ifdef SIGNED_CMP_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      l_q     <= l_d;
      e_q     <= e_d;
      g_q     <= g_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
`ifdef SIGNED_CMP_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule
